// File: rtl/fila_pedidos.sv
// Elevator request queue: button edge capture, duplicate filtering and a circular FIFO of floors.
// Optional IGNORA_ANDAR_ATUAL_EN drops requests for the current floor while the car is idle.
module fila_pedidos #(
    parameter int unsigned ANDARES       = 8,
    parameter int unsigned LARGURA_ANDAR = 3,
    parameter int unsigned PROFUNDIDADE  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ANDARES-1:0]            botoes,
    input  logic                          limpar,
    input  logic                          shift,
    input  logic [LARGURA_ANDAR-1:0]      andarAtual,
    output logic                          temDestino,
    output logic [LARGURA_ANDAR-1:0]      destino,
    output logic                          sobe,
    output logic                          chegouDestino,
    output logic                          cheia,
    output logic [$clog2(PROFUNDIDADE):0] ocupacao,
    output logic [ANDARES-1:0]            pendentes
);

    localparam int unsigned PW = $clog2(PROFUNDIDADE);
    localparam int unsigned OW = PW + 1;
    localparam logic [OW-1:0] Cheio = OW'(PROFUNDIDADE);

    logic [ANDARES-1:0]       botoes_ant_q, botoes_ant_d;
    logic [ANDARES-1:0]       captura_q, captura_d;
    logic [ANDARES-1:0]       pendentes_q, pendentes_d;
    logic [LARGURA_ANDAR-1:0] fila_q [PROFUNDIDADE];
    logic [LARGURA_ANDAR-1:0] fila_d [PROFUNDIDADE];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]            ocupacao_q, ocupacao_d;

    logic                     vazio, pop, push, descarta, tem_captura;
    logic [LARGURA_ANDAR-1:0] sel;
    logic [ANDARES-1:0]       sel_mask, bordas;

    assign vazio       = (ocupacao_q == '0);
    assign pop         = shift && !vazio;
    assign tem_captura = |captura_q;
    assign bordas      = botoes & ~botoes_ant_q;

    // Lowest-index pending capture wins; iterating downwards leaves the lowest in sel.
    always_comb begin
        sel      = '0;
        sel_mask = '0;
        for (int i = int'(ANDARES) - 1; i >= 0; i--) begin
            if (captura_q[i]) begin
                sel         = LARGURA_ANDAR'(i);
                sel_mask    = '0;
                sel_mask[i] = 1'b1;
            end
        end
    end

`ifdef IGNORA_ANDAR_ATUAL_EN
    assign descarta = tem_captura && vazio && (sel == andarAtual);
`else
    assign descarta = 1'b0;
`endif

    // A pop in the same cycle frees the slot a full queue needs.
    assign push = tem_captura && !descarta && ((ocupacao_q != Cheio) || pop);

    always_comb begin
        botoes_ant_d = botoes;
        fila_d       = fila_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ocupacao_d   = ocupacao_q;
        captura_d    = captura_q;
        pendentes_d  = pendentes_q;

        if (push || descarta) begin
            captura_d = captura_d & ~sel_mask;
        end
        // Edges for queued floors, or for the floor being pushed now, are duplicates.
        captura_d = captura_d | (bordas & ~pendentes_q & ~(push ? sel_mask : '0));

        if (pop) begin
            for (int i = 0; i < int'(ANDARES); i++) begin
                if (fila_q[rd_ptr_q] == LARGURA_ANDAR'(i)) begin
                    pendentes_d[i] = 1'b0;
                end
            end
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            fila_d[wr_ptr_q] = sel;
            pendentes_d      = pendentes_d | sel_mask;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        ocupacao_d = ocupacao_q + OW'(push) - OW'(pop);

        if (limpar) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ocupacao_d  = '0;
            captura_d   = '0;
            pendentes_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botoes_ant_q <= '0;
            captura_q    <= '0;
            pendentes_q  <= '0;
            fila_q       <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ocupacao_q   <= '0;
        end else begin
            botoes_ant_q <= botoes_ant_d;
            captura_q    <= captura_d;
            pendentes_q  <= pendentes_d;
            fila_q       <= fila_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ocupacao_q   <= ocupacao_d;
        end
    end

    // Stale FIFO contents are hidden while empty so destino reads 0.
    assign temDestino    = !vazio;
    assign destino       = vazio ? '0 : fila_q[rd_ptr_q];
    assign sobe          = (destino > andarAtual);
    assign chegouDestino = temDestino && (destino == andarAtual);
    assign cheia         = (ocupacao_q == Cheio);
    assign ocupacao      = ocupacao_q;
    assign pendentes     = pendentes_q;

endmodule

// File: tb/tb_fila_pedidos.sv
// Scoreboard bench for fila_pedidos (depth 4): expected floors queued at stimulus time,
// checked by a monitor whenever the control side pops the head.
module tb_fila_pedidos;

    localparam int unsigned ANDARES = 8;
    localparam int unsigned LA      = 3;
    localparam int unsigned PROF    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    botoes = '0;
    logic          limpar = 1'b0;
    logic          shift = 1'b0;
    logic [LA-1:0] andarAtual = '0;
    logic          temDestino, sobe, chegouDestino, cheia;
    logic [LA-1:0] destino;
    logic [2:0]    ocupacao;
    logic [7:0]    pendentes;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    fila_pedidos #(
        .ANDARES      (ANDARES),
        .LARGURA_ANDAR(LA),
        .PROFUNDIDADE (PROF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .limpar       (limpar),
        .shift        (shift),
        .andarAtual   (andarAtual),
        .temDestino   (temDestino),
        .destino      (destino),
        .sobe         (sobe),
        .chegouDestino(chegouDestino),
        .cheia        (cheia),
        .ocupacao     (ocupacao),
        .pendentes    (pendentes)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [7:0] mask);
        botoes = mask;
        tick();
        botoes = '0;
    endtask

    // Monitor: every accepted pop must present the next expected floor.
    always @(negedge clock) begin
        if (reset && shift && temDestino && !limpar) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got destino=%0d expected no entry", destino);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (32'(destino) !== e) begin
                    failures++;
                    $display("FAIL pop_destino: got %0d expected %0d", destino, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_temDestino", 32'(temDestino), 0);
        chk("rst_destino", 32'(destino), 0);
        chk("rst_sobe", 32'(sobe), 0);
        chk("rst_cheia", 32'(cheia), 0);
        chk("rst_ocupacao", 32'(ocupacao), 0);
        chk("rst_pendentes", 32'(pendentes), 0);
        tick();
        tick();
        reset = 1'b1;

        // 1: single request, two-edge latency
        andarAtual = 3'd2;
        press(8'h20);
        exp_q.push_back(5);
        chk("t1_lat_temDestino", 32'(temDestino), 0);
        tick();
        chk("t1_temDestino", 32'(temDestino), 1);
        chk("t1_destino", 32'(destino), 5);
        chk("t1_sobe", 32'(sobe), 1);
        chk("t1_chegou", 32'(chegouDestino), 0);
        chk("t1_ocupacao", 32'(ocupacao), 1);
        chk("t1_pendentes", 32'(pendentes), 32'h20);

        // 2: held and re-pressed button while queued
        botoes = 8'h20;
        repeat (10) tick();
        botoes = '0;
        tick();
        press(8'h20);
        repeat (3) tick();
        chk("t2_no_dup", 32'(ocupacao), 1);
        shift = 1'b1;
        tick();
        shift = 1'b0;
        chk("t2_temDestino", 32'(temDestino), 0);
        chk("t2_pendentes", 32'(pendentes), 0);

        // 3: three simultaneous edges queue lowest first
        press(8'h4A);
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(6);
        tick();
        chk("t3_first", 32'(destino), 1);
        chk("t3_ocup1", 32'(ocupacao), 1);
        tick();
        chk("t3_ocup2", 32'(ocupacao), 2);
        tick();
        chk("t3_ocup3", 32'(ocupacao), 3);
        chk("t3_pendentes", 32'(pendentes), 32'h4A);
        shift = 1'b1;
        repeat (3) tick();
        shift = 1'b0;
        chk("t3_drained", 32'(ocupacao), 0);

        // 4: overflow into held captures, pop admits next floor same cycle
        press(8'hFF);
        for (int f = 0; f < 8; f++) exp_q.push_back(f);
        repeat (4) tick();
        chk("t4_cheia", 32'(cheia), 1);
        chk("t4_ocupacao", 32'(ocupacao), 4);
        chk("t4_pendentes", 32'(pendentes), 32'h0F);
        shift = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_ocup_steady", 32'(ocupacao), 4);
        end
        chk("t4_pend_hi", 32'(pendentes), 32'hF0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_ocup_drain", 32'(ocupacao), 32'(3 - k));
        end
        shift = 1'b0;
        chk("t4_pend_empty", 32'(pendentes), 0);

        // 5: request for the current floor while idle
        andarAtual = 3'd4;
        press(8'h10);
        tick();
`ifdef IGNORA_ANDAR_ATUAL_EN
        chk("t5_temDestino", 32'(temDestino), 0);
        chk("t5_ocupacao", 32'(ocupacao), 0);
`else
        exp_q.push_back(4);
        chk("t5_chegou", 32'(chegouDestino), 1);
        chk("t5_ocupacao", 32'(ocupacao), 1);
        shift = 1'b1;
        tick();
        shift = 1'b0;
`endif
        chk("t5_pendentes", 32'(pendentes), 0);

        // 6a: limpar wins over a simultaneous shift
        andarAtual = 3'd0;
        press(8'h0E);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        repeat (3) tick();
        chk("t6_ocup3", 32'(ocupacao), 3);
        limpar = 1'b1;
        shift  = 1'b1;
        tick();
        limpar = 1'b0;
        shift  = 1'b0;
        exp_q.delete();
        chk("t6_clr_ocup", 32'(ocupacao), 0);
        chk("t6_clr_pend", 32'(pendentes), 0);
        chk("t6_clr_tem", 32'(temDestino), 0);

        // 6b: asynchronous reset mid-push clears outputs before any edge
        press(8'h06);
        tick();
        chk("t6_prepush", 32'(ocupacao), 1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_ocup", 32'(ocupacao), 0);
        chk("t6_rst_tem", 32'(temDestino), 0);
        chk("t6_rst_pend", 32'(pendentes), 0);
        chk("t6_rst_dest", 32'(destino), 0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("t6_no_stale", 32'(ocupacao), 0);
        press(8'h80);
        exp_q.push_back(7);
        tick();
        chk("t6_new_dest", 32'(destino), 7);
        chk("t6_new_sobe", 32'(sobe), 1);
        shift = 1'b1;
        tick();
        shift = 1'b0;
        tick();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
